soc_system_sysid_ext: RTL and testbench

- Parametrised successor to the system-ID slave: an Avalon-MM slave exposing a multi-word identification map.
  - Read-only: system ID, build timestamp, build-info word.
  - Read/write: scratch register.
  - 64-bit uptime counter with atomic high-word snapshot and a control register.
- Pipelined reads with fixed latency and readdatavalid.
- Sits on the HPS lightweight bridge; software uses it for board identification and as a coarse time base.

---
 rtl/soc_system_sysid_ext.sv | 157 +++++++++++++++
 tb/tb_soc_system_sysid_ext.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// soc_system_sysid_ext
//
// Avalon-MM identification slave for the HPS lightweight bridge. Exposes a
// small word map: read-only ID / build timestamp / build-info words, a
// byte-enabled scratch register, a free-running 64-bit uptime counter with
// an atomic high-word snapshot, a control register and a capabilities word.
//
// Ports:
//   clock          single clock for all logic
//   reset_n        synchronous, active-low reset
//   address        word address (ADDR_W bits; words 8 and above unmapped)
//   read           read strobe, one cycle per request, always accepted
//   write          write strobe, one cycle per request, always accepted
//   writedata      write data
//   byteenable     byte lanes for writes
//   readdata       read data, meaningful only while readdatavalid=1 (else 0)
//   readdatavalid  one-cycle pulse per accepted read
//
// Handshake: there is no waitrequest. A request is accepted in every cycle
// its strobe is high. Each accepted read produces exactly one readdatavalid
// pulse READ_LATENCY cycles later, in request order, carrying the data
// selected from register state in the accept cycle. Reset drops any read
// still in the pipeline.
//
// Word map:
//   0 ID  1 TIMESTAMP  2 BUILD_INFO  3 SCRATCH (RW)
//   4 UPTIME_LO (read also loads shadow <= counter[63:32])
//   5 UPTIME_HI (returns shadow)  6 CTRL {clr, en}  7 CAPS
//
// UPTIME_RST is the counter reset value; leave it at zero in a real build.
// It exists so a bench can start the counter close to a carry or a wrap.
// ADDR_W must be at least 3.
// ---------------------------------------------------------------------------
module soc_system_sysid_ext #(
    parameter logic [31:0] ID           = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [31:0] BUILD_INFO   = 32'h0000_0000,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SCRATCH_RST  = 32'h0000_0000,
    parameter logic [63:0] UPTIME_RST   = 64'h0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [1:0]  LAT_FIELD = 2'(READ_LATENCY);
    localparam logic [31:0] CAPS      = {24'h0, 3'd0, LAT_FIELD, 3'b111};

    // Register state
    logic [31:0] scratch;
    logic [63:0] uptime;
    logic [31:0] shadow;
    logic        en;

    // Address decode: only words 0..7 are mapped.
    logic [31:0] addr_ext;
    logic        mapped;
    logic [2:0]  word;

    assign addr_ext = 32'(address);
    assign mapped   = (addr_ext < 32'd8);
    assign word     = address[2:0];

    logic wr_scratch;
    logic wr_ctrl;
    logic rd_lo;

    assign wr_scratch = write && mapped && (word == 3'd3);
    assign wr_ctrl    = write && mapped && (word == 3'd6) && byteenable[0];
    assign rd_lo      = read  && mapped && (word == 3'd4);

    // Read mux over pre-edge state, so a colliding write is not visible.
    logic [31:0] rd_sel;

    always_comb begin
        rd_sel = 32'h0;
        if (mapped) begin
            case (word)
                3'd0:    rd_sel = ID;
                3'd1:    rd_sel = TIMESTAMP;
                3'd2:    rd_sel = BUILD_INFO;
                3'd3:    rd_sel = scratch;
                3'd4:    rd_sel = uptime[31:0];
                3'd5:    rd_sel = shadow;
                3'd6:    rd_sel = {31'h0, en};
                default: rd_sel = CAPS;
            endcase
        end
    end

    // Register updates
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RST;
            uptime  <= UPTIME_RST;
            shadow  <= 32'h0;
            en      <= 1'b1;
        end else begin
            if (wr_scratch) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch[8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end

            // Shadow captures the pre-edge high word, so LO/HI pair is atomic
            // even when this edge also carries or clears the counter.
            if (rd_lo) begin
                shadow <= uptime[63:32];
            end

            // clr wins over the increment; the increment uses the old en.
            if (wr_ctrl && writedata[1]) begin
                uptime <= 64'h0;
            end else if (en) begin
                uptime <= uptime + 64'd1;
            end

            if (wr_ctrl) begin
                en <= writedata[0];
            end
        end
    end

    // Read return pipeline: READ_LATENCY register stages, data forced to 0
    // in stages that carry no read.
    logic [READ_LATENCY-1:0][31:0] pipe_data;
    logic [READ_LATENCY-1:0]       pipe_vld;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pipe_data <= '0;
            pipe_vld  <= '0;
        end else begin
            pipe_data[0] <= read ? rd_sel : 32'h0;
            pipe_vld[0]  <= read;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_data[i] <= pipe_data[i-1];
                pipe_vld[i]  <= pipe_vld[i-1];
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// tb_soc_system_sysid_ext
//
// Directed bench for soc_system_sysid_ext. A behavioural model of the word
// map predicts every read return (value and due cycle); a compare process
// checks each readdatavalid against it. Directed groups additionally check
// returned words against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_soc_system_sysid_ext;

    localparam int          ADDR_W  = 4;
    localparam int          RL      = 2;
    localparam logic [31:0] P_ID    = 32'h5913_A80B;
    localparam logic [31:0] P_TS    = 32'hACD4_1802;
    localparam logic [31:0] P_BI    = 32'h2024_0517;
    localparam logic [31:0] P_SCR   = 32'hA5A5_0F0F;
    localparam logic [63:0] P_UPT   = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] SNAP_AT = 64'hFFFF_FFFF_FFFF_FFFE;

    // ---------------- clock / reset ----------------
    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [3:0]        byteenable = '0;
    logic [31:0]       readdata;
    logic              readdatavalid;

    always #5 clock = ~clock;

    soc_system_sysid_ext #(
        .ID(P_ID), .TIMESTAMP(P_TS), .BUILD_INFO(P_BI), .ADDR_W(ADDR_W),
        .READ_LATENCY(RL), .SCRATCH_RST(P_SCR), .UPTIME_RST(P_UPT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- model ----------------
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] got_q[$];
    int          ecount = 0;
    logic        rst_seen = 1'b0;
    logic [31:0] m_scratch;
    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic        m_en;

    function automatic logic [31:0] model_word(input int a);
        case (a)
            0: return P_ID;
            1: return P_TS;
            2: return P_BI;
            3: return m_scratch;
            4: return m_cnt[31:0];
            5: return m_shadow;
            6: return {31'h0, m_en};
            7: return {24'h0, 3'd0, 2'(RL), 3'b111};
            default: return 32'h0;
        endcase
    endfunction

    initial forever begin
        @(posedge clock);
        rst_seen = !reset_n;
        if (!reset_n) begin
            exp_q.delete();
            due_q.delete();
            m_scratch = P_SCR;
            m_cnt     = P_UPT;
            m_shadow  = 32'h0;
            m_en      = 1'b1;
        end else begin
            logic [63:0] cnt_before;
            logic        en_before;
            int          a;
            cnt_before = m_cnt;
            en_before  = m_en;
            a          = int'(address);
            if (read) begin
                exp_q.push_back(model_word(a));
                due_q.push_back(ecount + RL - 1);
                if (a == 4) m_shadow = cnt_before[63:32];
            end
            if (write && a == 3) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_scratch[8*b +: 8] = writedata[8*b +: 8];
            end
            m_cnt = en_before ? cnt_before + 64'd1 : cnt_before;
            if (write && a == 6 && byteenable[0]) begin
                if (writedata[1]) m_cnt = 64'h0;
                m_en = writedata[0];
            end
        end
        ecount++;
    end

    // ---------------- compare (every cycle) ----------------
    initial forever begin
        @(negedge clock);
        if (rst_seen) begin
            n_tests++;
            if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_out: valid=%b data=%h, required valid=0 data=0",
                         readdatavalid, readdata);
            end
        end else if (readdatavalid === 1'b1) begin
            got_q.push_back(readdata);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: data=%h at cycle %0d, required no valid",
                         readdata, ecount - 1);
            end else begin
                logic [31:0] e;
                int          d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                if (d != ecount - 1 || readdata !== e) begin
                    n_fail++;
                    $display("FAIL read_return: data=%h cycle=%0d, required data=%h cycle=%0d",
                             readdata, ecount - 1, e, d);
                end
            end
        end else if (readdatavalid !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_x: readdatavalid=%b, required 0/1", readdatavalid);
        end else if (due_q.size() > 0 && due_q[0] <= ecount - 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_valid: no valid at cycle %0d, required data=%h",
                     ecount - 1, exp_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic r, input logic w, input int a,
                       input logic [31:0] d, input logic [3:0] be);
        @(posedge clock);
        #1;
        read       = r;
        write      = w;
        address    = ADDR_W'(a);
        writedata  = d;
        byteenable = be;
    endtask

    task automatic rd(input int a);
        cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, d, be);
    endtask

    task automatic idle(input int n);
        cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_lit(input string name, input logic [31:0] exp);
        n_tests++;
        if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no read returned, required %h", name, exp);
        end else begin
            logic [31:0] g;
            g = got_q.pop_front();
            if (g !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", name, g, exp);
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] lo_a;
        logic [31:0] lo_b;
        bit          reached;

        // Reset held 3 cycles with a read pulse in the middle.
        cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
        rd(3);
        cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
        reset_n = 1'b1;
        got_q.delete();
        rd(3);
        rd(6);
        idle(RL + 3);
        chk_lit("rst_scratch", P_SCR);
        chk_lit("rst_ctrl", 32'h1);

        // Snapshot across a 64-bit wrap.
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m_cnt == SNAP_AT) begin
                reached = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        n_tests++;
        if (!reached) begin
            n_fail++;
            $display("FAIL snap_reach: model counter %h, required %h", m_cnt, SNAP_AT);
        end
        got_q.delete();
        read = 1'b1; address = ADDR_W'(4);
        cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
        rd(5);
        rd(4);
        rd(5);
        idle(RL + 3);
        chk_lit("snap_lo", 32'hFFFF_FFFE);
        chk_lit("snap_hi", 32'hFFFF_FFFF);
        chk_lit("wrap_lo", 32'h0000_0001);
        chk_lit("wrap_hi", 32'h0000_0000);

        // ID map, back-to-back reads including an unmapped word.
        got_q.delete();
        rd(0); rd(1); rd(2); rd(7); rd(9);
        idle(RL + 3);
        chk_lit("map_id", P_ID);
        chk_lit("map_ts", P_TS);
        chk_lit("map_bi", P_BI);
        chk_lit("map_caps", 32'h0000_0017);
        chk_lit("map_unmapped", 32'h0);

        // Scratch byte enables and RO protection.
        got_q.delete();
        wr(3, 32'hDEAD_BEEF, 4'hF);
        wr(3, 32'h0000_1234, 4'b0001);
        rd(3);
        wr(3, 32'h0000_0000, 4'h0);
        rd(3);
        wr(0, 32'hFFFF_FFFF, 4'hF);
        wr(9, 32'hFFFF_FFFF, 4'hF);
        rd(0);
        idle(RL + 3);
        chk_lit("scr_be", 32'hDEAD_BE34);
        chk_lit("scr_be0", 32'hDEAD_BE34);
        chk_lit("ro_id", P_ID);

        // Control: stop, clear while stopped, clear and run.
        got_q.delete();
        wr(6, 32'h0, 4'hF);
        rd(4);
        idle(10);
        rd(4);
        rd(6);
        wr(6, 32'h2, 4'hF);
        idle(3);
        rd(4);
        rd(6);
        wr(6, 32'h3, 4'hF);
        rd(4);
        rd(4);
        rd(6);
        idle(RL + 3);
        lo_a = got_q.size() > 0 ? got_q.pop_front() : 32'hX;
        lo_b = got_q.size() > 0 ? got_q.pop_front() : 32'hX;
        n_tests++;
        if (lo_a !== lo_b || $isunknown(lo_a)) begin
            n_fail++;
            $display("FAIL stopped_lo: second %h, required equal to first %h", lo_b, lo_a);
        end
        chk_lit("ctrl_off", 32'h0);
        chk_lit("clr_stopped_lo", 32'h0);
        chk_lit("clr_stopped_ctrl", 32'h0);
        chk_lit("clr_run_lo0", 32'h0);
        chk_lit("clr_run_lo1", 32'h1);
        chk_lit("ctrl_on", 32'h1);

        // Read/write collision on SCRATCH.
        got_q.delete();
        wr(3, 32'h0, 4'hF);
        cyc(1'b1, 1'b1, 3, 32'h1111_1111, 4'hF);
        rd(3);
        idle(RL + 3);
        chk_lit("coll_old", 32'h0);
        chk_lit("coll_new", 32'h1111_1111);

        // Reset during an in-flight read: no valid may emerge.
        got_q.delete();
        rd(3);
        cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        rd(3);
        idle(RL + 3);
        chk_lit("post_rst_scratch", P_SCR);
        n_tests++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_count: %0d extra returns, required 0", got_q.size());
        end

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
